// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Valid/ready/data handshake bundle used on both sides of the
//               pipe_stage_reg stage. The master drives valid and data; the
//               slave drives ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
) ();

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface : pipe_stage_reg_if
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised pipeline register with a valid/ready handshake
//               and a 2-entry skid buffer. in_ready is registered, so
//               back-pressure never forms a combinational path between
//               stages. A synchronous flush squashes all held words.
//               Optional stall statistics are compiled in with the macro
//               PIPE_STAGE_STATS_EN (saturating stall counter on stall_cnt_o);
//               without it stall_cnt_o is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  pipe_stage_reg_if.slave  in_if,
  pipe_stage_reg_if.master out_if,
  output logic [1:0]       occupancy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // State code doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] main_q;       // head word, drives out_data
  logic [WIDTH-1:0] skid_q;       // second word while FULL
  logic             out_valid_q;
  logic             in_ready_q;

  logic w_acc;
  logic w_pop;

  assign w_acc = in_if.valid & in_ready_q;
  assign w_pop = out_valid_q & out_if.ready;

  // Handshake FSM: moves words between M and S and keeps both flags registered.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      state_q     <= ST_EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_acc) begin
            state_q     <= ST_ONE;
            main_q      <= in_if.data;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && !w_pop) begin
            state_q    <= ST_FULL;
            skid_q     <= in_if.data;
            in_ready_q <= 1'b0;
          end else if (w_acc && w_pop) begin
            // Same-cycle pass-through: head leaves, new word becomes head.
            main_q <= in_if.data;
          end else if (w_pop) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can change anything.
          if (w_pop) begin
            state_q    <= ST_ONE;
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          // Unused encoding: recover to a clean empty stage.
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_if.ready  = in_ready_q;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = main_q;
  assign occupancy_o  = state_q;

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // Count stalled cycles, saturating at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_if.ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Only reset clears the counter; flush leaves the statistics intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule : pipe_stage_reg
`default_nettype wire
